prog_launcher: RTL

- Host-side initiator for the processor's Start/Ack program handshake. It drives the processor's reset and start inputs and waits for its done flag.
- On a Go request it resets the processor once, then runs NUM_PROGS programs back to back.
- Measures the cycle count of each program and reports per-program results. Aborts the sequence on timeout.
- Sits beside the processor top level as the bench/host sequencer.

---
 rtl/prog_launcher.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/prog_launcher.sv
// rtl/prog_launcher.sv - host sequencer driving the processor start/ack program handshake
module prog_launcher #(
  parameter int NUM_PROGS    = 3,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 16'hFFFF,
  parameter int RST_CYCLES   = 2,
  parameter int START_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_go,
  input  logic             i_dut_ack,
  output logic             o_dut_reset,
  output logic             o_dut_start,
  output logic             o_busy,
  output logic [3:0]       o_prog_idx,
  output logic             o_result_valid,
  output logic [3:0]       o_result_idx,
  output logic [CNT_W-1:0] o_result_cycles,
  output logic             o_timed_out,
  output logic             o_done
);

  localparam int              PH_W          = 16;
  localparam logic [PH_W-1:0] LP_RST_LOAD   = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] LP_START_LOAD = PH_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TIMEOUT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [3:0]      LP_LAST_IDX   = 4'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DUT_RST = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_RESULT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PH_W-1:0]   r_phase;
  logic [CNT_W-1:0]  r_cyc_cnt;
  logic              r_armed;
  logic [3:0]        r_prog_idx;
  logic [3:0]        r_result_idx;
  logic [CNT_W-1:0]  r_result_cycles;
  logic              r_timed_out;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_complete;
  logic              w_timeout;
  logic              w_last;

  // Count including the current RUN cycle, saturating so a hung program never wraps.
  assign w_cnt_inc  = (r_cyc_cnt == LP_CNT_MAX) ? r_cyc_cnt : r_cyc_cnt + CNT_W'(1);
  // Ack only counts once it has been seen low since this program's start.
  assign w_complete = (r_state == S_RUN) && i_dut_ack && r_armed;
  assign w_timeout  = (r_state == S_RUN) && !w_complete && (w_cnt_inc == LP_TIMEOUT);
  assign w_last     = (r_prog_idx == LP_LAST_IDX);

  assign o_prog_idx      = r_prog_idx;
  assign o_result_idx    = r_result_idx;
  assign o_result_cycles = r_result_cycles;
  assign o_timed_out     = r_timed_out;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    w_state_nxt    = r_state;
    o_dut_reset    = 1'b0;
    o_dut_start    = 1'b0;
    o_busy         = 1'b1;
    o_result_valid = 1'b0;
    o_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_go) w_state_nxt = S_DUT_RST;
      end
      S_DUT_RST: begin
        o_dut_reset = 1'b1;
        if (r_phase == '0) w_state_nxt = S_START;
      end
      S_START: begin
        o_dut_start = 1'b1;
        if (r_phase == '0) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_complete || w_timeout) w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        o_result_valid = 1'b1;
        if (r_timed_out || w_last) w_state_nxt = S_DONE;
        else                       w_state_nxt = S_START;
      end
      S_DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
        if (i_go) w_state_nxt = S_DUT_RST;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Phase/cycle counters, arming, program index and captured results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase         <= '0;
      r_cyc_cnt       <= '0;
      r_armed         <= 1'b0;
      r_prog_idx      <= '0;
      r_result_idx    <= '0;
      r_result_cycles <= '0;
      r_timed_out     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_go) begin
            r_phase     <= LP_RST_LOAD;
            r_prog_idx  <= '0;
            r_timed_out <= 1'b0;
          end
        end
        S_DUT_RST: begin
          if (r_phase == '0) begin
            r_phase <= LP_START_LOAD;
            r_armed <= 1'b0;
          end else begin
            r_phase <= r_phase - 16'd1;
          end
        end
        S_START: begin
          r_cyc_cnt <= '0;
          if (!i_dut_ack) r_armed <= 1'b1;
          if (r_phase != '0) r_phase <= r_phase - 16'd1;
        end
        S_RUN: begin
          r_cyc_cnt <= w_cnt_inc;
          if (!i_dut_ack) r_armed <= 1'b1;
          if (w_complete || w_timeout) begin
            r_result_idx    <= r_prog_idx;
            r_result_cycles <= w_cnt_inc;
          end
          if (w_timeout) r_timed_out <= 1'b1;
        end
        S_RESULT: begin
          if (!(r_timed_out || w_last)) begin
            r_prog_idx <= r_prog_idx + 4'd1;
            r_phase    <= LP_START_LOAD;
            r_armed    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
